rom_stream_reader: RTL and testbench

Sequencer that sits directly upstream of the 256x8 combinational ROM and drives its `address`, `read_en` and `ce` inputs. On a start command it reads a contiguous run of ROM words and streams them out over a valid/ready interface, one word per cycle at full rate. A 2-entry output FIFO decouples the ROM read from the downstream `out_ready`, so `out_ready` has no combinational path to the ROM address.

---
 rtl/rom_stream_pkg.sv | 15 +
 rtl/sync_fifo2.sv | 51 +++++
 rtl/rom_stream_reader.sv | 89 ++++++++
 tb/tb_rom_stream_reader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM stream reader.
// Imported by the top level and its sub-modules.
package rom_stream_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO.
// Head word is presented combinationally from storage.
module sync_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       count,
   output logic             valid
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign valid   = (count != 2'd0);
   assign push_ok = push && (count != 2'd2);
   assign pop_ok  = pop && valid;
   assign pop_data = mem[rd_ptr];

   // storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_stream_reader.sv
// Streams a contiguous run of ROM words over valid/ready.
// Reads are gated on registered FIFO occupancy only.
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_read_en,
   output logic                  rom_ce,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [ADDR_WIDTH:0]     remaining;
   logic [1:0]              fifo_count;
   logic                    issue;
   logic                    pop;

   assign issue       = (state == READ) && (fifo_count < 2'd2);
   assign pop         = out_valid && out_ready;
   assign rom_address = cur_addr;
   assign rom_read_en = issue;
   assign rom_ce      = issue;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   sync_fifo2 #(
      .WIDTH(DATA_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (issue),
      .push_data(rom_data),
      .pop      (pop),
      .pop_data (out_data),
      .count    (fifo_count),
      .valid    (out_valid)
   );

   // run sequencer with address and word counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  cur_addr  <= start_addr;
                  remaining <= length;
                  state     <= (length != '0) ? READ : DONE;
               end
            end
            READ: begin
               if (issue) begin
                  cur_addr  <= cur_addr + ADDR_ONE;
                  remaining <= remaining - REM_ONE;
                  if (remaining == REM_ONE) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_count == 2'd0 ||
                   (fifo_count == 2'd1 && pop))
                  state <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized bench for rom_stream_reader.
// Expected streams come from a ROM image and run arithmetic.
module tb_rom_stream_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] start_addr;
   logic [8:0] length;
   logic       busy;
   logic       done;
   logic [7:0] rom_address;
   logic       rom_read_en;
   logic       rom_ce;
   logic [7:0] rom_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   logic [7:0] mem [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rom_data = mem[rom_address];

   rom_stream_reader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .rom_address(rom_address),
      .rom_read_en(rom_read_en),
      .rom_ce     (rom_ce),
      .rom_data   (rom_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_addr"}, int'(rom_address), 0);
      check({tag, "_rd"}, int'(rom_read_en), 0);
      check({tag, "_ce"}, int'(rom_ce), 0);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_data"}, int'(out_data), 0);
   endtask

   // mode 0: ready high, 1: random ready, 2: ready low for 6 cycles
   // poke: extra start while busy; rst_word: reset when that word shows
   task automatic run(input int sa, input int len, input int mode,
                      input bit poke, input int rst_word);
      int rd_n;
      int wr_n;
      bit fin;
      bit was_reset;
      logic [7:0] ea;
      start_addr = sa[7:0];
      length     = len[8:0];
      start      = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      rd_n      = 0;
      wr_n      = 0;
      fin       = 1'b0;
      was_reset = 1'b0;
      for (int k = 1; k <= 3000 && !fin; k++) begin
         if (k > 1) @(negedge clk);
         unique case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (k > 6);
         endcase
         if (poke) begin
            start = (k == 3);
            if (k == 3) begin
               start_addr = ~sa[7:0];
               length     = 9'd5;
            end
         end
         check("busy", int'(busy), 1);
         check("ce_eq_rd", int'(rom_ce), int'(rom_read_en));
         if (mode == 0 && k == 1)
            check("first_valid_early", int'(out_valid), 0);
         if (mode == 0 && k == 2 && len > 0)
            check("first_valid", int'(out_valid), 1);
         if (rom_read_en) begin
            ea = 8'(sa + rd_n);
            check("rd_in_range", int'(rd_n < len), 1);
            check("rom_addr", int'(rom_address), int'(ea));
            rd_n++;
         end
         if (mode == 2 && k <= 6) begin
            check("bp_reads", int'(rd_n <= 2), 1);
            if (out_valid)
               check("bp_hold", int'(out_data), int'(mem[8'(sa)]));
            if (k == 6) check("bp_two_reads", rd_n, 2);
         end
         if (rst_word > 0 && wr_n == rst_word - 1 && out_valid) begin
            check("rst_no_done", int'(done), 0);
            reset = 1'b1;
            @(negedge clk);
            check_zero_outputs("rst");
            reset     = 1'b0;
            fin       = 1'b1;
            was_reset = 1'b1;
         end else begin
            if (out_valid && out_ready) begin
               ea = 8'(sa + wr_n);
               check("word_in_range", int'(wr_n < len), 1);
               check("out_data", int'(out_data), int'(mem[ea]));
               wr_n++;
            end
            if (done) begin
               fin = 1'b1;
               check("words", wr_n, len);
               check("reads", rd_n, len);
               if (mode == 0)
                  check("done_cycle", k, (len == 0) ? 1 : len + 2);
            end
         end
      end
      start = 1'b0;
      if (!fin) check("timeout", 0, 1);
      if (!was_reset) begin
         @(negedge clk);
         check("idle_busy", int'(busy), 0);
         check("single_done", int'(done), 0);
         check("idle_valid", int'(out_valid), 0);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      length     = '0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      run(8'h10, 4, 0, 1'b0, 0);
      run(8'hFE, 4, 0, 1'b0, 0);
      run(8'h20, 6, 2, 1'b0, 0);
      run(8'h33, 0, 0, 1'b0, 0);
      run(8'h40, 5, 0, 1'b1, 0);
      run(8'h80, 256, 1, 1'b0, 0);
      run(8'h60, 8, 0, 1'b0, 3);
      run(8'hC8, 3, 0, 1'b0, 0);
      for (int i = 0; i < 6; i++)
         run(int'($urandom_range(0, 255)),
             int'($urandom_range(1, 20)), 1, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
